// File: rtl/imm_decode_stage.sv
// Immediate-generation stage: decodes the immediate format from the opcode,
// extends the immediate, computes pc + imm and flags illegal encodings.
// Results pass through a main output register plus one skid entry.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   flush                    synchronous flush of both entries
//   in_valid/in_ready        input handshake (in_ready is registered)
//   in_inst, in_pc           instruction word and its PC
//   out_valid/out_ready      output handshake
//   out_imm, out_target      extended immediate and pc + imm
//   out_fmt, out_illegal     format code and illegal-encoding flag
module imm_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
  localparam logic [2:0] FMT_Z    = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  entry_t     dec;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Format decode and immediate extension
  always_comb begin
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
      end
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.fmt = FMT_SH;
          // RV32 shamt is 5 bits; inst[25] set would be a 6-bit shift
          if (XLEN == 32 && in_inst[25]) begin
            dec.illegal = 1'b1;
          end else begin
            dec.imm = {{(XLEN-SHW){1'b0}}, in_inst[20+SHW-1:20]};
          end
        end else begin
          dec.fmt = FMT_I;
          dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                   in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                   in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'h000};
      end
      7'b1110011: begin
        if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
          dec.fmt = FMT_Z;
          dec.imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
        end
      end
      7'b0110011: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.target = in_pc + dec.imm;
  end

  assign accept = in_valid && in_ready_q;
  assign drain  = main_valid_q && out_ready;

  // Elastic buffer next state; skid can only be full when no input is accepted
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      if (accept) begin
        if (!main_valid_q || drain) begin
          main_d       = dec;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_target  = main_q.target;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed testbench for imm_decode_stage (RV32 instance plus an RV64 instance).
module tb_imm_decode_stage;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_imm, out_target;
  logic [2:0]  out_fmt;

  logic        in_valid64, in_ready64, out_valid64, out_illegal64;
  logic [31:0] in_inst64;
  logic [63:0] in_pc64, out_imm64, out_target64;
  logic [2:0]  out_fmt64;

  int errors = 0;
  int checks = 0;

  imm_decode_stage #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64),
    .out_target(out_target64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if ({out_imm, out_target} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {out_imm, out_target}); end
    checks++; if ({out_fmt, out_illegal} !== 4'h0) begin errors++; $display("FAIL reset_fmt: got %h expected 0", {out_fmt, out_illegal}); end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    vec_t v[$];
    v.push_back('{32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0});
    v.push_back('{32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 3'd3, 1'b0});
    v.push_back('{32'h01F09093, 32'h0000_0200, 32'h0000_001F, 32'h0000_021F, 3'd6, 1'b0});
    v.push_back('{32'h02009093, 32'h0000_0200, 32'h0000_0000, 32'h0000_0200, 3'd6, 1'b1});
    v.push_back('{32'h4050D093, 32'h0000_0000, 32'h0000_0005, 32'h0000_0005, 3'd6, 1'b0});
    v.push_back('{32'h0200006F, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010, 3'd4, 1'b0});
    v.push_back('{32'h800000B7, 32'h0000_0040, 32'h8000_0000, 32'h8000_0040, 3'd5, 1'b0});
    v.push_back('{32'h00001097, 32'h0000_2000, 32'h0000_1000, 32'h0000_3000, 3'd5, 1'b0});
    v.push_back('{32'hFE112E23, 32'h0000_0300, 32'hFFFF_FFFC, 32'h0000_02FC, 3'd2, 1'b0});
    v.push_back('{32'h340FD073, 32'h0000_0010, 32'h0000_001F, 32'h0000_002F, 3'd7, 1'b0});
    v.push_back('{32'h00000073, 32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 3'd0, 1'b0});
    v.push_back('{32'h002081B3, 32'h0000_0020, 32'h0000_0000, 32'h0000_0020, 3'd0, 1'b0});
    v.push_back('{32'h0000007F, 32'h0000_0030, 32'h0000_0000, 32'h0000_0030, 3'd0, 1'b1});
    v.push_back('{32'h00C080E7, 32'h0000_1000, 32'h0000_000C, 32'h0000_100C, 3'd1, 1'b0});
    v.push_back('{32'h8000E093, 32'h0000_1000, 32'hFFFF_F800, 32'h0000_0800, 3'd1, 1'b0});
    out_ready = 1'b1;
    foreach (v[i]) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = v[i].inst; in_pc = v[i].pc;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_valid: got %b expected 1", i, out_valid); end
      checks++; if (out_imm !== v[i].imm) begin errors++; $display("FAIL dec%0d_imm: got %h expected %h", i, out_imm, v[i].imm); end
      checks++; if (out_target !== v[i].tgt) begin errors++; $display("FAIL dec%0d_target: got %h expected %h", i, out_target, v[i].tgt); end
      checks++; if ({out_fmt, out_illegal} !== {v[i].fmt, v[i].ill}) begin
        errors++; $display("FAIL dec%0d_fmt_ill: got %0d/%b expected %0d/%b", i, out_fmt, out_illegal, v[i].fmt, v[i].ill);
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] k;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'(i)) begin
          errors++; $display("FAIL b2b_%0d: got %b/%h expected 1/%h", i, out_valid, out_imm, 32'(i));
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready); end
      end
      k = 12'(i + 1);
      in_valid = 1'b1; in_inst = {k, 20'h00093}; in_pc = 32'h0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'h4) begin
      errors++; $display("FAIL b2b_last: got %b/%h expected 1/00000004", out_valid, out_imm);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h01100093; in_pc = 32'h0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'h11) begin errors++; $display("FAIL stall_a: got %b/%h expected 1/00000011", out_valid, out_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1: got %b expected 1", in_ready); end
    in_inst = 32'h02200093;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready0: got %b expected 0", in_ready); end
    checks++; if (out_imm !== 32'h11) begin errors++; $display("FAIL stall_hold1: got %h expected 00000011", out_imm); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'h11 || out_target !== 32'h11) begin
      errors++; $display("FAIL stall_hold2: got %b/%h/%h expected 1/00000011/00000011", out_valid, out_imm, out_target);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'h22) begin errors++; $display("FAIL stall_b: got %b/%h expected 1/00000022", out_valid, out_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b expected 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_nodup: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h01100093; in_pc = 32'h0;
    @(negedge clk);
    in_inst = 32'h02200093;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b/%b expected 0/1", in_ready, out_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full: got %b/%b expected 0/1", out_valid, in_ready); end
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %b expected 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h0000_0040;
    @(negedge clk);
    in_inst = 32'h0000007F;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_hs: got %b/%b expected 0/1", out_valid, in_ready); end
    checks++; if ({out_imm, out_target, out_fmt, out_illegal} !== 68'h0) begin
      errors++; $display("FAIL rstmid_data: got %h/%h/%0d/%b expected 0", out_imm, out_target, out_fmt, out_illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected 0", out_valid); end
  endtask

  task automatic test_rv64();
    @(negedge clk);
    in_valid64 = 1'b1; in_inst64 = 32'h800000B7; in_pc64 = 64'h1000;
    @(negedge clk);
    checks++; if (out_imm64 !== 64'hFFFF_FFFF_8000_0000 || out_fmt64 !== 3'd5) begin
      errors++; $display("FAIL rv64_lui: got %h/%0d expected ffffffff80000000/5", out_imm64, out_fmt64);
    end
    checks++; if (out_target64 !== 64'hFFFF_FFFF_8000_1000) begin errors++; $display("FAIL rv64_target: got %h expected ffffffff80001000", out_target64); end
    in_inst64 = 32'h03F09093; in_pc64 = 64'h0;
    @(negedge clk);
    checks++; if (out_imm64 !== 64'h3F || out_fmt64 !== 3'd6 || out_illegal64 !== 1'b0) begin
      errors++; $display("FAIL rv64_slli63: got %h/%0d/%b expected 3f/6/0", out_imm64, out_fmt64, out_illegal64);
    end
    in_inst64 = 32'h02009093;
    @(negedge clk);
    in_valid64 = 1'b0;
    checks++; if (out_imm64 !== 64'h20 || out_illegal64 !== 1'b0 || out_valid64 !== 1'b1) begin
      errors++; $display("FAIL rv64_slli32: got %h/%b/%b expected 20/0/1", out_imm64, out_illegal64, out_valid64);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    in_valid64 = 1'b0; in_inst64 = '0; in_pc64 = '0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_rv64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
